alu_mc: RTL and testbench

Multi-cycle, parametrised integer ALU for the RV32IM datapath of the pipelined core; next generation of the single-cycle combinational ALU. Performs RV32I arithmetic/logic/shift/compare ops in one cycle and M-extension multiply/divide iteratively, with valid/ready handshakes on both sides so the EX stage can stall on long ops. Results and flags are registered and held until consumed.

---
 rtl/alu_mc_pkg.sv | 46 ++++
 rtl/alu_mc_if.sv | 34 +++
 rtl/alu_mc_muldiv.sv | 89 ++++++++
 rtl/alu_mc.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg
// Shared definitions for the multi-cycle ALU slice:
//   XLEN_DEFAULT  - default operand/result width
//   op_e          - 5-bit operation code (codes above OP_REMU are undefined)
//   state_e       - control FSM states
//   is_iterative  - true for the multiply/divide class
// The multiply/divide class is only implemented when ALU_MC_MULDIV_EN is defined.

package alu_mc_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        OP_PASSB  = 5'd0,
        OP_ADD    = 5'd1,
        OP_SUB    = 5'd2,
        OP_SLL    = 5'd3,
        OP_SLT    = 5'd4,
        OP_SLTU   = 5'd5,
        OP_XOR    = 5'd6,
        OP_SRL    = 5'd7,
        OP_SRA    = 5'd8,
        OP_OR     = 5'd9,
        OP_AND    = 5'd10,
        OP_MUL    = 5'd11,
        OP_MULH   = 5'd12,
        OP_MULHSU = 5'd13,
        OP_MULHU  = 5'd14,
        OP_DIV    = 5'd15,
        OP_DIVU   = 5'd16,
        OP_REM    = 5'd17,
        OP_REMU   = 5'd18
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply/divide ops occupy one contiguous code range.
    function automatic logic is_iterative(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if
// Request/response bundle of the multi-cycle ALU.
//   master: drives in_valid, op, a, b, out_ready; sees in_ready, out_valid, c, flags, err
//   slave : the ALU side of the same signals
// Flags: zf (c==0), sf (c msb), cf (a<b unsigned), of (ADD/SUB signed overflow),
// err (op code undefined in this build).

interface alu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] c;
    logic            zf;
    logic            sf;
    logic            cf;
    logic            of;
    logic            err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, c, zf, sf, cf, of, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, c, zf, sf, cf, of, err
    );
endinterface

// File: rtl/alu_mc_muldiv.sv
// alu_mc_muldiv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide on magnitudes.
// Only instantiated when ALU_MC_MULDIV_EN is defined.
//   clk, rstn        - clock, asynchronous active-low reset
//   start            - load magnitudes and begin XLEN steps
//   is_div           - 1: divide, 0: multiply
//   mag_a, mag_b     - multiplier/dividend and multiplicand/divisor magnitudes
//   done             - the step taken at the coming edge is the last one
//   hi_next, lo_next - register contents after the current step
//                      (multiply: {hi,lo} product; divide: hi=remainder, lo=quotient)

module alu_mc_muldiv #(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    output logic            done,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opb_q;
    logic            div_q;
    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // done is exposed combinationally so the parent can register the final
    // result on the same edge as the last step, keeping latency at XLEN+1.
    assign done = busy_q && (cnt_q == '0);

    // One step: multiply adds the multiplicand into the upper half when the
    // multiplier lsb is set, then shifts the pair right; divide shifts the
    // dividend msb into the remainder and keeps the difference if non-negative.
    // In the divide case a negative difference implies shifted[XLEN] is 0,
    // so the restored remainder always fits in XLEN bits.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opb_q};
        hi_next = sum[XLEN:1];
        lo_next = {sum[0], lo_q[XLEN-1:1]};
        if (div_q) begin
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Operand load on start, then XLEN steps counted down from XLEN-1 to 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            div_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            hi_q   <= '0;
            lo_q   <= mag_a;
            opb_q  <= mag_b;
            div_q  <= is_div;
            busy_q <= 1'b1;
            cnt_q  <= CW'(XLEN-1);
        end else if (busy_q) begin
            hi_q  <= hi_next;
            lo_q  <= lo_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc
// Multi-cycle integer ALU for the RV32IM EX stage. Single-cycle ops finish one
// cycle after accept; multiply/divide run XLEN radix-2 steps (XLEN+1 cycles).
// Results and flags are registered and held until out_ready.
//   clk, rstn - clock, asynchronous active-low reset
//   bus       - alu_mc_if.slave: in_valid/in_ready, op, a, b,
//               out_valid/out_ready, c, zf, sf, cf, of, err
// Build option: ALU_MC_MULDIV_EN enables the multiply/divide class; without it
// those codes behave as undefined ops and no multiply/divide logic exists.

module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic     clk,
    input  logic     rstn,
    alu_mc_if.slave  bus
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q;
    state_e          state_d;
    logic            in_ready_c;
    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] fast_res;
    logic            fast_err;
    logic            start_iter;
    logic            acc_zf;
    logic            acc_sf;
    logic            acc_cf;
    logic            acc_of;
    logic            md_done;
    logic [XLEN-1:0] iter_res;
    logic            iter_cf;
    logic [XLEN-1:0] c_q;
    logic            zf_q;
    logic            sf_q;
    logic            cf_q;
    logic            of_q;
    logic            err_q;

    assign shamt = bus.b[SHW-1:0];

    // Result for everything that completes in one cycle, computed straight
    // from the request so it can be registered on the accept edge. Divide
    // fast paths (by zero, signed overflow) live here too; the iterative
    // result for the other multiply/divide cases comes from alu_mc_muldiv.
    always_comb begin
        fast_res = '0;
        fast_err = 1'b0;
        case (bus.op)
            OP_PASSB: fast_res = bus.b;
            OP_ADD:   fast_res = bus.a + bus.b;
            OP_SUB:   fast_res = bus.a - bus.b;
            OP_SLL:   fast_res = bus.a << shamt;
            OP_SLT:   fast_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU:  fast_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            OP_XOR:   fast_res = bus.a ^ bus.b;
            OP_SRL:   fast_res = bus.a >> shamt;
            OP_SRA:   fast_res = $unsigned($signed(bus.a) >>> shamt);
            OP_OR:    fast_res = bus.a | bus.b;
            OP_AND:   fast_res = bus.a & bus.b;
`ifdef ALU_MC_MULDIV_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: fast_res = '0;
            OP_DIV, OP_DIVU: fast_res = (bus.b == '0) ? '1 : bus.a;
            OP_REM, OP_REMU: fast_res = (bus.b == '0) ? bus.a : '0;
`endif
            default:  fast_err = 1'b1;
        endcase
    end

    // Flags for a one-cycle completion. Undefined ops clear every flag.
    always_comb begin
        acc_zf = (fast_res == '0);
        acc_sf = fast_res[XLEN-1];
        acc_cf = (bus.a < bus.b);
        acc_of = 1'b0;
        if (bus.op == OP_ADD) begin
            acc_of = (bus.a[XLEN-1] == bus.b[XLEN-1]) && (fast_res[XLEN-1] != bus.a[XLEN-1]);
        end else if (bus.op == OP_SUB) begin
            acc_of = (bus.a[XLEN-1] != bus.b[XLEN-1]) && (fast_res[XLEN-1] != bus.a[XLEN-1]);
        end
        if (fast_err) begin
            acc_zf = 1'b0;
            acc_sf = 1'b0;
            acc_cf = 1'b0;
            acc_of = 1'b0;
        end
    end

`ifdef ALU_MC_MULDIV_EN
    logic [4:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;
    logic              a_neg;
    logic              b_neg;
    logic              neg_in;
    logic              div_fast;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   md_hi;
    logic [XLEN-1:0]   md_lo;
    logic [2*XLEN-1:0] prod;

    // Sign decode at accept: the datapath works on magnitudes and a single
    // negate flag fixes the sign at the end. The remainder takes the sign of
    // the dividend, the quotient/product the xor of both operand signs.
    always_comb begin
        a_neg  = (bus.op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.a[XLEN-1];
        b_neg  = (bus.op inside {OP_MULH, OP_DIV, OP_REM}) && bus.b[XLEN-1];
        mag_a  = a_neg ? -bus.a : bus.a;
        mag_b  = b_neg ? -bus.b : bus.b;
        neg_in = (bus.op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        div_fast = ((bus.op >= OP_DIV) && (bus.b == '0))
                 || ((bus.op inside {OP_DIV, OP_REM}) && (bus.a == MIN_NEG) && (bus.b == '1));
        start_iter = is_iterative(bus.op) && !div_fast;
    end

    alu_mc_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk     (clk),
        .rstn    (rstn),
        .start   (accept && start_iter),
        .is_div  (bus.op >= OP_DIV),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .done    (md_done),
        .hi_next (md_hi),
        .lo_next (md_lo)
    );

    // Request capture for the iterative class: op selects the final result
    // and the operands give cf at completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            neg_q <= 1'b0;
        end else if (accept) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            neg_q <= neg_in;
        end
    end

    // Final selection and sign correction of the last datapath step.
    always_comb begin
        prod     = {md_hi, md_lo};
        if (neg_q) begin
            prod = -prod;
        end
        iter_res = prod[XLEN-1:0];
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU: iter_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              iter_res = neg_q ? -md_lo : md_lo;
            OP_REM, OP_REMU:              iter_res = neg_q ? -md_hi : md_hi;
            default:                      iter_res = prod[XLEN-1:0];
        endcase
        iter_cf = (a_q < b_q);
    end
`else
    assign start_iter = 1'b0;
    assign md_done    = 1'b0;
    assign iter_res   = '0;
    assign iter_cf    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake. DONE hands over to a new request in the same
    // cycle the result is consumed, so in_ready follows out_ready there.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_c = 1'b1;
            ST_BUSY: begin
                if (md_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        accept = bus.in_valid && in_ready_c;
        if (accept) begin
            state_d = start_iter ? ST_BUSY : ST_DONE;
        end
    end

    // Output registers load on a one-cycle accept or on the last iterative
    // step and otherwise hold, so they are stable while a result waits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_q   <= '0;
            zf_q  <= 1'b0;
            sf_q  <= 1'b0;
            cf_q  <= 1'b0;
            of_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (accept && !start_iter) begin
            c_q   <= fast_err ? '0 : fast_res;
            zf_q  <= acc_zf;
            sf_q  <= acc_sf;
            cf_q  <= acc_cf;
            of_q  <= acc_of;
            err_q <= fast_err;
        end else if ((state_q == ST_BUSY) && md_done) begin
            c_q   <= iter_res;
            zf_q  <= (iter_res == '0);
            sf_q  <= iter_res[XLEN-1];
            cf_q  <= iter_cf;
            of_q  <= 1'b0;
            err_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.c         = c_q;
    assign bus.zf        = zf_q;
    assign bus.sf        = sf_q;
    assign bus.cf        = cf_q;
    assign bus.of        = of_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc
// Self-checking bench for alu_mc: a table of single-cycle vectors with
// hand-computed results and flags, plus hand-written sequences for reset,
// result hold under back-pressure, back-to-back issue, reset during an
// operation and (with ALU_MC_MULDIV_EN) the iterative multiply/divide class.

module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rstn;

    alu_mc_if #(.XLEN(XLEN)) bus ();

    alu_mc #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // flags packed as {zf, sf, cf, of, err}
    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [4:0]  flags;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [4:0] flags);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.flags = flags;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] flags_now();
        return {27'b0, bus.zf, bus.sf, bus.cf, bus.of, bus.err};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; presents one request, returns at the falling
    // edge after the accepting rising edge with in_valid dropped.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

`ifdef ALU_MC_MULDIV_EN
    // Issues an iterative op and measures accept-to-out_valid latency in cycles.
    task automatic run_iter(input string name, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_c, input logic [4:0] exp_f);
        int lat;
        applyStimulus(op, a, b);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checkOutput($sformatf("%s latency", name), 32'(lat), 32'd33);
        checkOutput($sformatf("%s c", name), bus.c, exp_c);
        checkOutput($sformatf("%s flags", name), flags_now(), {27'b0, exp_f});
    endtask
`endif

    initial begin
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;

        add_vec(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010);
        add_vec(OP_SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 5'b01100);
        add_vec(OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 5'b10000);
        add_vec(OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00010);
        add_vec(OP_PASSB, 32'h00000001, 32'h00001234, 32'h00001234, 5'b00100);
        add_vec(OP_SLL,   32'h00000001, 32'h00000023, 32'h00000008, 5'b00100);
        add_vec(OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000);
        add_vec(OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000);
        add_vec(OP_SRL,   32'h80000000, 32'h00000021, 32'h40000000, 5'b00000);
        add_vec(OP_SRA,   32'h80000000, 32'h00000021, 32'hC0000000, 5'b01000);
        add_vec(OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 5'b00100);
        add_vec(OP_OR,    32'h0000000F, 32'h000000F0, 32'h000000FF, 5'b00100);
        add_vec(OP_AND,   32'hFFFF0000, 32'h0FF00FF0, 32'h0FF00000, 5'b00000);
        add_vec(5'd31,    32'h00000005, 32'h00000009, 32'h00000000, 5'b00001);
        add_vec(OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000);
        add_vec(OP_SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'b10100);
`ifdef ALU_MC_MULDIV_EN
        add_vec(OP_DIVU,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 5'b01000);
        add_vec(OP_REMU,  32'h00000009, 32'h00000000, 32'h00000009, 5'b00000);
        add_vec(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'b01100);
        add_vec(OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 5'b10100);
`else
        add_vec(OP_MUL,   32'h00000006, 32'h00000007, 32'h00000000, 5'b00001);
        add_vec(OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000000, 5'b00001);
`endif

        // Reset state, observed while reset is held.
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset c", bus.c, 32'd0);
        checkOutput("reset flags", flags_now(), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Table of one-cycle vectors, consumed immediately.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d valid", i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("vec%0d c", i), bus.c, vecs[i].c);
            checkOutput($sformatf("vec%0d flags", i), flags_now(), {27'b0, vecs[i].flags});
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle after table", 32'(bus.out_valid), 32'd0);

        // Result held under back-pressure; a request presented meanwhile is ignored.
        bus.out_ready = 1'b0;
        applyStimulus(OP_SUB, 32'd3, 32'd5);
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("hold%0d valid", k), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("hold%0d c", k), bus.c, 32'hFFFFFFFE);
            checkOutput($sformatf("hold%0d flags", k), flags_now(), 32'b01100);
            checkOutput($sformatf("hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release valid", 32'(bus.out_valid), 32'd0);
        checkOutput("release in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back XOR, OR, AND: one result per cycle.
        bus.in_valid = 1'b1;
        bus.op = OP_XOR; bus.a = 32'h12345678; bus.b = 32'hFFFF0000;
        @(posedge clk); @(negedge clk);
        checkOutput("b2b xor valid", 32'(bus.out_valid), 32'd1);
        checkOutput("b2b xor c", bus.c, 32'hEDCB5678);
        checkOutput("b2b in_ready", 32'(bus.in_ready), 32'd1);
        bus.op = OP_OR; bus.a = 32'h12345678; bus.b = 32'h0F0F0F0F;
        @(posedge clk); @(negedge clk);
        checkOutput("b2b or valid", 32'(bus.out_valid), 32'd1);
        checkOutput("b2b or c", bus.c, 32'h1F3F5F7F);
        bus.op = OP_AND;
        @(posedge clk); @(negedge clk);
        checkOutput("b2b and valid", 32'(bus.out_valid), 32'd1);
        checkOutput("b2b and c", bus.c, 32'h02040608);
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checkOutput("b2b idle", 32'(bus.out_valid), 32'd0);

`ifdef ALU_MC_MULDIV_EN
        // Iterative class.
        run_iter("mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'b01000);
        run_iter("div",    OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 5'b01000);
        run_iter("rem",    OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 5'b01000);
        run_iter("mul",    OP_MUL,    32'h00000006, 32'hFFFFFFF9, 32'hFFFFFFD6, 5'b01100);
        run_iter("mulh",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'b10000);
        run_iter("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b01000);
        run_iter("divu",   OP_DIVU,   32'd100,      32'd7,        32'd14,       5'b00000);
        run_iter("remu",   OP_REMU,   32'd100,      32'd7,        32'd2,        5'b00000);
        @(posedge clk); @(negedge clk);

        // Reset pulsed while a divide is in flight.
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
        repeat (5) @(negedge clk);
        checkOutput("busy valid", 32'(bus.out_valid), 32'd0);
        checkOutput("busy in_ready", 32'(bus.in_ready), 32'd0);
`else
        // Reset pulsed while a result is waiting.
        bus.out_ready = 1'b0;
        applyStimulus(OP_SUB, 32'd3, 32'd5);
        checkOutput("pre-reset valid", 32'(bus.out_valid), 32'd1);
`endif
        #2 rstn = 1'b0;
        #1;
        checkOutput("async reset valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("async reset c", bus.c, 32'd0);
        @(negedge clk);
        rstn          = 1'b1;
        bus.out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); @(negedge clk);
                if (bus.out_valid) seen++;
            end
            checkOutput("no valid after reset", 32'(seen), 32'd0);
        end
        checkOutput("in_ready after reset", 32'(bus.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
